// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives a 1-cycle-latency instruction memory
// and presents a registered instruction to decode.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall               decode cannot accept; instr outputs hold
//   branch_taken        1-cycle redirect pulse, wins over stall
//   branch_target       redirect address, low two bits ignored
//   imem_req/imem_addr  read strobe and address (= pc)
//   imem_rdata          read data, live the cycle after a request
//   instr/instr_pc      registered instruction and its address
//   instr_valid         instr is a live instruction
//   op/funct            instr[31:26] / instr[5:0]
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [5:0]  op,
    output logic [5:0]  funct
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        SKID = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        pend;
    logic [31:0] pend_pc;
    logic [31:0] skid;
    logic [31:0] skid_pc;
    logic        unused_tgt;

    assign unused_tgt = ^branch_target[1:0];

    assign imem_req  = (state == RUN || state == SKID)
                     && !stall && !branch_taken;
    assign imem_addr = pc;
    assign op        = instr[31:26];
    assign funct     = instr[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            pend        <= 1'b0;
            pend_pc     <= 32'h0;
            skid        <= 32'h0;
            skid_pc     <= 32'h0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
        end else begin
            pend    <= imem_req;
            pend_pc <= pc;
            if (imem_req)
                pc <= pc + 32'd4;
            if (branch_taken) begin
                // Any in-flight response or skid word is dropped:
                // pend clears via imem_req=0, SKID is left.
                pc          <= {branch_target[31:2], 2'b00};
                instr_valid <= 1'b0;
                state       <= RUN;
            end else begin
                unique case (state)
                    BOOT: state <= RUN;
                    RUN: begin
                        if (!stall) begin
                            // Invalid cycles keep the last word shown.
                            if (pend) begin
                                instr    <= imem_rdata;
                                instr_pc <= pend_pc;
                            end
                            instr_valid <= pend;
                        end else if (pend) begin
                            skid    <= imem_rdata;
                            skid_pc <= pend_pc;
                            state   <= SKID;
                        end
                    end
                    SKID: begin
                        if (!stall) begin
                            instr       <= skid;
                            instr_pc    <= skid_pc;
                            instr_valid <= 1'b1;
                            state       <= RUN;
                        end
                    end
                    default: state <= BOOT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/branch
// traffic compared every cycle against a queue-based delivery model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [5:0]  op;
    logic [5:0]  funct;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;
    logic        instr_valid2;
    logic [5:0]  op2;
    logic [5:0]  funct2;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .op(op), .funct(funct)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .instr(instr2), .instr_pc(instr_pc2),
        .instr_valid(instr_valid2), .op(op2), .funct(funct2)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h2000_0000 + {2'b00, a[31:2]};
    endfunction

    // Memory returns garbage when not read, so stale data is visible.
    always @(posedge clk) begin
        imem_rdata  <= imem_req  ? memf(imem_addr)  : $urandom;
        imem_rdata2 <= imem_req2 ? memf(imem_addr2) : $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: q lists addresses fetched but not yet shown to decode.
    logic        m_boot;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] q[$];
    logic        m_req;

    assign m_req = !rst && !m_boot && !stall && !branch_taken;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_boot  = 1'b1;
            m_pc    = 32'h0;
            m_valid = 1'b0;
            m_ipc   = 32'h0;
            q.delete();
        end else if (branch_taken) begin
            q.delete();
            m_valid = 1'b0;
            m_boot  = 1'b0;
            m_pc    = branch_target & 32'hFFFF_FFFC;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (!stall) begin
            if (q.size() > 0) begin
                m_ipc   = q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        logic [31:0] w;
        logic [5:0]  wop;
        logic [5:0]  wfn;
        chk("valid", {31'b0, instr_valid}, {31'b0, m_valid});
        chk("req", {31'b0, imem_req}, {31'b0, m_req});
        chk("addr", imem_addr, m_pc);
        if (m_valid) begin
            w   = memf(m_ipc);
            wop = w[31:26];
            wfn = w[5:0];
            chk("instr_pc", instr_pc, m_ipc);
            chk("instr", instr, w);
            chk("op", {26'b0, op}, {26'b0, wop});
            chk("funct", {26'b0, funct}, {26'b0, wfn});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shown(input string name, input logic [31:0] pc);
        chk({name, "_v"}, {31'b0, instr_valid}, 32'd1);
        chk({name, "_pc"}, instr_pc, pc);
    endtask

    task automatic gap(input string name);
        chk({name, "_v"}, {31'b0, instr_valid}, 32'd0);
    endtask

    initial begin
        cyc(3);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_op", {26'b0, op}, 32'h0);
        chk("rst_addr2", imem_addr2, 32'hFFFF_FFF8);
        rst = 1'b0;
        #1;
        chk("c0_req", {31'b0, imem_req}, 32'd0);
        cyc(1);
        chk("c1_req", {31'b0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        cyc(1);
        gap("c2");
        cyc(1);
        shown("c3", 32'h0);
        chk("c3_instr", instr, 32'h2000_0000);
        chk("c3_op", {26'b0, op}, 32'h08);
        shown("w0", 32'h0);
        chk("w0_pc2", instr_pc2, 32'hFFFF_FFF8);
        chk("w0_v2", {31'b0, instr_valid2}, 32'd1);
        cyc(1);
        shown("c4", 32'h4);
        chk("w1_pc2", instr_pc2, 32'hFFFF_FFFC);
        cyc(1);
        shown("c5", 32'h8);
        chk("w2_pc2", instr_pc2, 32'h0000_0000);
        chk("w2_in2", instr2, 32'h2000_0000);

        stall = 1'b1;
        #1;
        chk("st0_req", {31'b0, imem_req}, 32'd0);
        cyc(1);
        shown("st1", 32'h8);
        chk("st1_req", {31'b0, imem_req}, 32'd0);
        cyc(1);
        shown("st2", 32'h8);
        chk("st2_req", {31'b0, imem_req}, 32'd0);
        cyc(1);
        stall = 1'b0;
        cyc(1);
        shown("rel0", 32'hC);
        chk("rel0_instr", instr, 32'h2000_0003);
        cyc(1);
        shown("rel1", 32'h10);

        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        cyc(1);
        branch_taken = 1'b0;
        gap("br1");
        cyc(1);
        gap("br2");
        cyc(1);
        shown("br3", 32'h100);
        chk("br3_instr", instr, 32'h2000_0040);

        cyc(1);
        stall = 1'b1;
        cyc(1);
        shown("sk1", 32'h104);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0100;
        cyc(1);
        branch_taken = 1'b0;
        stall        = 1'b0;
        gap("sk2");
        cyc(1);
        gap("sk3");
        cyc(1);
        shown("sk4", 32'h100);
        cyc(1);
        shown("sk5", 32'h104);

        cyc(2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'b0, instr_valid}, 32'd0);
        chk("ar_req", {31'b0, imem_req}, 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(3);
        shown("re3", 32'h0);
        cyc(1);
        shown("re4", 32'h4);

        for (int i = 0; i < 3000; i++) begin
            stall         = ($urandom_range(0, 2) == 0);
            branch_taken  = ($urandom_range(0, 11) == 0);
            branch_target = $urandom;
            if ($urandom_range(0, 3) != 0)
                branch_target[31:12] = 20'h0;
            cyc(1);
        end
        stall        = 1'b0;
        branch_taken = 1'b0;
        cyc(6);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
